// File: rtl/adc_readout_pkg.sv
// Shared types and default geometry for the ADC capture/readout path.
package adc_readout_pkg;

  localparam int unsigned ADC_DATA_WIDTH  = 12;
  localparam int unsigned ADC_BUFFER_SIZE = 4096;
  localparam int unsigned ADC_ADDR_WIDTH  = 12;

  typedef enum logic [2:0] {
    IDLE,
    PRETRIG,
    ARMED,
    POSTTRIG,
    DONE
  } capture_state_t;

endpackage

// File: rtl/adc_capture_ctrl_if.sv
// Sample stream in, buffer write port out: the capture controller's data path.
interface adc_capture_ctrl_if
  import adc_readout_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = ADC_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = ADC_ADDR_WIDTH
);

  logic                  sample_valid;
  logic [DATA_WIDTH-1:0] sample_data;
  logic                  trigger;
  logic                  write_en;
  logic [ADDR_WIDTH-1:0] write_addr;
  logic [DATA_WIDTH-1:0] data_in;

  // ADC front end / observer of the buffer write port
  modport master (
    output sample_valid, sample_data, trigger,
    input  write_en, write_addr, data_in
  );

  // capture controller
  modport slave (
    input  sample_valid, sample_data, trigger,
    output write_en, write_addr, data_in
  );

endinterface

// File: rtl/adc_level_trig.sv
// Rising level-crossing detector; exists only when ADC_CAPTURE_LEVEL_TRIG_EN is defined.
`ifdef ADC_CAPTURE_LEVEL_TRIG_EN
module adc_level_trig
  import adc_readout_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = ADC_DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  restart,
  input  logic                  sample_valid,
  input  logic [DATA_WIDTH-1:0] sample_data,
  input  logic [DATA_WIDTH-1:0] trig_level,
  output logic                  level_hit_c
);

  logic [DATA_WIDTH-1:0] prev_sample;
  logic                  prev_ok;

  // prev_ok blocks a crossing on the first valid sample after a restart
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prev_sample <= '0;
      prev_ok     <= 1'b0;
    end else if (restart) begin
      prev_ok     <= 1'b0;
    end else if (sample_valid) begin
      prev_sample <= sample_data;
      prev_ok     <= 1'b1;
    end
  end

  assign level_hit_c = sample_valid && prev_ok &&
                       (prev_sample < trig_level) && (sample_data >= trig_level);

endmodule
`endif

// File: rtl/adc_capture_ctrl.sv
// Pre/post-trigger ring-buffer write controller for adc_buffer.
// Optional level-crossing trigger: define ADC_CAPTURE_LEVEL_TRIG_EN.
module adc_capture_ctrl
  import adc_readout_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = ADC_DATA_WIDTH,
  parameter int unsigned BUFFER_SIZE  = ADC_BUFFER_SIZE,
  parameter int unsigned ADDR_WIDTH   = ADC_ADDR_WIDTH,
  parameter int unsigned PRE_SAMPLES  = 1024,
  parameter int unsigned POST_SAMPLES = 3072
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  arm,
  input  logic                  abort,
`ifdef ADC_CAPTURE_LEVEL_TRIG_EN
  input  logic [DATA_WIDTH-1:0] trig_level,
`endif
  adc_capture_ctrl_if.slave     bus,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] trig_addr,
  output logic [ADDR_WIDTH-1:0] start_addr
);

  localparam int unsigned CNT_W = ADDR_WIDTH + 1;

  if (PRE_SAMPLES < 1 || POST_SAMPLES < 1 ||
      PRE_SAMPLES + POST_SAMPLES > BUFFER_SIZE ||
      (32'(1) << ADDR_WIDTH) != BUFFER_SIZE) begin : g_param_err
    $error("adc_capture_ctrl: invalid PRE/POST/BUFFER_SIZE/ADDR_WIDTH combination");
  end

  capture_state_t        state;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [CNT_W-1:0]      pre_cnt;
  logic [CNT_W-1:0]      post_cnt;
  logic                  trig_hit_c;
  logic                  wr_accept_c;

`ifdef ADC_CAPTURE_LEVEL_TRIG_EN
  logic level_hit_c;

  adc_level_trig #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_level_trig (
    .clock        (clock),
    .reset_n      (reset_n),
    .restart      (arm | abort),
    .sample_valid (bus.sample_valid),
    .sample_data  (bus.sample_data),
    .trig_level   (trig_level),
    .level_hit_c  (level_hit_c)
  );

  assign trig_hit_c = bus.trigger | level_hit_c;
`else
  assign trig_hit_c = bus.trigger;
`endif

  // Samples are written only while capturing and never in an arm/abort cycle
  assign wr_accept_c = bus.sample_valid && !arm && !abort &&
                       (state == PRETRIG || state == ARMED || state == POSTTRIG);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      wr_ptr         <= '0;
      pre_cnt        <= '0;
      post_cnt       <= '0;
      bus.write_en   <= 1'b0;
      bus.write_addr <= '0;
      bus.data_in    <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      trig_addr      <= '0;
      start_addr     <= '0;
    end else begin
      bus.write_en <= 1'b0;
      if (wr_accept_c) begin
        bus.write_en   <= 1'b1;
        bus.write_addr <= wr_ptr;
        bus.data_in    <= bus.sample_data;
        wr_ptr         <= wr_ptr + ADDR_WIDTH'(1);
      end

      if (abort) begin
        state <= IDLE;
        busy  <= 1'b0;
        done  <= 1'b0;
      end else if (arm) begin
        state    <= PRETRIG;
        wr_ptr   <= '0;
        pre_cnt  <= '0;
        post_cnt <= '0;
        busy     <= 1'b1;
        done     <= 1'b0;
      end else begin
        unique case (state)
          PRETRIG: begin
            if (bus.sample_valid) begin
              pre_cnt <= pre_cnt + CNT_W'(1);
              if (pre_cnt + CNT_W'(1) == CNT_W'(PRE_SAMPLES)) state <= ARMED;
            end
          end
          ARMED: begin
            if (bus.sample_valid && trig_hit_c) begin
              trig_addr  <= wr_ptr;
              start_addr <= wr_ptr - ADDR_WIDTH'(PRE_SAMPLES);
              post_cnt   <= CNT_W'(1);
              if (POST_SAMPLES == 1) begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                state <= POSTTRIG;
              end
            end
          end
          POSTTRIG: begin
            if (bus.sample_valid) begin
              post_cnt <= post_cnt + CNT_W'(1);
              if (post_cnt + CNT_W'(1) == CNT_W'(POST_SAMPLES)) begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Directed bench for adc_capture_ctrl with PRE=4, POST=4, a 16-deep ring.
module tb_adc_capture_ctrl;

  localparam int unsigned DW   = 12;
  localparam int unsigned AW   = 4;
  localparam int unsigned SIZE = 16;
  localparam int unsigned PRE  = 4;
  localparam int unsigned POST = 4;

  logic clock = 1'b0;
  logic reset_n;
  logic arm;
  logic abort;
  logic [DW-1:0] trig_level;
  logic busy;
  logic done;
  logic [AW-1:0] trig_addr;
  logic [AW-1:0] start_addr;

  int checks = 0;
  int errors = 0;

  adc_capture_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  adc_capture_ctrl #(
    .DATA_WIDTH   (DW),
    .BUFFER_SIZE  (SIZE),
    .ADDR_WIDTH   (AW),
    .PRE_SAMPLES  (PRE),
    .POST_SAMPLES (POST)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .arm        (arm),
    .abort      (abort),
`ifdef ADC_CAPTURE_LEVEL_TRIG_EN
    .trig_level (trig_level),
`endif
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .trig_addr  (trig_addr),
    .start_addr (start_addr)
  );

  always #5 clock = ~clock;

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [DW-1:0] d, input logic t);
    bus.sample_valid = 1'b1;
    bus.sample_data  = d;
    bus.trigger      = t;
    cyc();
    bus.sample_valid = 1'b0;
    bus.trigger      = 1'b0;
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    cyc();
    arm = 1'b0;
  endtask

  task automatic chk_write(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d);
    chk({tag, "_we"}, 32'(bus.write_en), 32'd1);
    chk({tag, "_addr"}, 32'(bus.write_addr), 32'(a));
    chk({tag, "_data"}, 32'(bus.data_in), 32'(d));
  endtask

  initial begin
    reset_n          = 1'b0;
    arm              = 1'b0;
    abort            = 1'b0;
    trig_level       = 12'hFFF;
    bus.sample_valid = 1'b0;
    bus.sample_data  = '0;
    bus.trigger      = 1'b0;
    cyc();
    cyc();
    chk("rst_we", 32'(bus.write_en), 32'd0);
    chk("rst_addr", 32'(bus.write_addr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_trig", 32'(trig_addr), 32'd0);
    reset_n = 1'b1;
    cyc();

    // Idle drops samples
    send(12'h055, 1'b1);
    chk("idle_we", 32'(bus.write_en), 32'd0);

    // Basic capture, with triggers during PRETRIG and without valid ignored
    pulse_arm();
    chk("arm_busy", 32'(busy), 32'd1);
    chk("arm_done", 32'(done), 32'd0);
    chk("arm_we", 32'(bus.write_en), 32'd0);
    for (int i = 0; i < 4; i++) begin
      send(DW'(12'h100 + i), (i == 1));
      chk_write("pre", AW'(i), DW'(12'h100 + i));
    end
    bus.trigger = 1'b1;
    cyc();
    bus.trigger = 1'b0;
    chk("novalid_we", 32'(bus.write_en), 32'd0);
    chk("novalid_trig", 32'(trig_addr), 32'd0);
    send(12'h104, 1'b1);
    chk_write("trigw", 4'd4, 12'h104);
    chk("basic_trig_addr", 32'(trig_addr), 32'd4);
    chk("basic_start_addr", 32'(start_addr), 32'd0);
    for (int i = 5; i < 8; i++) begin
      chk("basic_not_done", 32'(done), 32'd0);
      send(DW'(12'h100 + i), 1'b0);
      chk_write("post", AW'(i), DW'(12'h100 + i));
    end
    chk("basic_done", 32'(done), 32'd1);
    chk("basic_busy", 32'(busy), 32'd0);
    send(12'h1AA, 1'b1);
    chk("frozen_we", 32'(bus.write_en), 32'd0);
    chk("frozen_done", 32'(done), 32'd1);
    chk("frozen_trig", 32'(trig_addr), 32'd4);

    // Re-arm from DONE, then a wrapping capture triggered on the 20th sample
    pulse_arm();
    chk("rearm_done", 32'(done), 32'd0);
    chk("rearm_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 23; i++) begin
      send(DW'(i), (i == 19));
      chk_write("wrap", AW'(i % 16), DW'(i));
      if (i < 22) chk("wrap_not_done", 32'(done), 32'd0);
    end
    chk("wrap_trig_addr", 32'(trig_addr), 32'd3);
    chk("wrap_start_addr", 32'(start_addr), 32'd15);
    chk("wrap_done", 32'(done), 32'd1);

    // arm and abort together in ARMED: abort wins
    pulse_arm();
    for (int i = 0; i < 4; i++) send(DW'(i), 1'b0);
    arm   = 1'b1;
    abort = 1'b1;
    cyc();
    arm   = 1'b0;
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    send(12'h077, 1'b1);
    chk("abort_idle_we", 32'(bus.write_en), 32'd0);

    // Reset mid-POSTTRIG: outputs clear without a clock edge
    pulse_arm();
    for (int i = 0; i < 4; i++) send(DW'(i), 1'b0);
    send(12'h004, 1'b1);
    send(12'h005, 1'b0);
    chk_write("prerst", 4'd5, 12'h005);
    #1 reset_n = 1'b0;
    #1;
    chk("arst_we", 32'(bus.write_en), 32'd0);
    chk("arst_addr", 32'(bus.write_addr), 32'd0);
    chk("arst_data", 32'(bus.data_in), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_trig", 32'(trig_addr), 32'd0);
    chk("arst_start", 32'(start_addr), 32'd0);
    reset_n = 1'b1;
    send(12'h006, 1'b1);
    chk("postrst_we", 32'(bus.write_en), 32'd0);
    send(12'h007, 1'b0);
    chk("postrst_we2", 32'(bus.write_en), 32'd0);

`ifdef ADC_CAPTURE_LEVEL_TRIG_EN
    // Level crossing: 0x800 -> 0x900 is not a crossing, 0x7FF -> 0x800 is
    trig_level = 12'h800;
    pulse_arm();
    send(12'h000, 1'b0);
    send(12'h000, 1'b0);
    send(12'h000, 1'b0);
    send(12'h800, 1'b0);
    send(12'h900, 1'b0);
    chk_write("lvl_nocross", 4'd4, 12'h900);
    chk("lvl_no_trig", 32'(trig_addr), 32'd0);
    send(12'h7FF, 1'b0);
    send(12'h800, 1'b0);
    chk("lvl_trig_addr", 32'(trig_addr), 32'd6);
    chk("lvl_start_addr", 32'(start_addr), 32'd2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
